remainder_check_18_18_4: RTL and testbench

//  Downstream stage of the iterative msb1-divisor quotient unit. It takes the

---
 rtl/remainder_check_18_18_4_pkg.sv | 16 +
 rtl/remainder_check_18_18_4.sv | 107 ++++++++++
 tb/tb_remainder_check_18_18_4.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/remainder_check_18_18_4_pkg.sv
// Shared encodings and default widths for the remainder check stage.
// The state encoding matches the upstream divider loop FSM.
package remainder_check_18_18_4_pkg;

    localparam int DEF_DW = 18;
    localparam int DEF_VW = 4;
    localparam int DEF_PW = DEF_DW + DEF_VW;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_INITS = 2'd1,
        ST_MUL   = 2'd3,
        ST_SUB   = 2'd2
    } state_t;

endpackage

// File: rtl/remainder_check_18_18_4.sv
// Recomputes quotient*divisor by shift-add (one divisor bit per clock, LSB first)
// and reports dividend - product with underflow, divide-by-zero and ok flags.
// Latency VW+2 clocks after start; a new start always restarts immediately.
module remainder_check_18_18_4
    import remainder_check_18_18_4_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int VW = DEF_VW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    input  logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          underflow,
    output logic          div_by_zero,
    output logic          ok,
    output logic          result_ready
);

    localparam int PW = DW + VW;
    localparam int KW = (VW > 1) ? $clog2(VW) : 1;

    state_t        state_q;
    logic [DW-1:0] dividend_q;
    logic [VW-1:0] divisor_q;
    logic [PW-1:0] mcand_q;
    logic [PW-1:0] acc_q;
    logic [KW-1:0] k_q;
    logic [DW-1:0] remainder_q;
    logic          underflow_q;
    logic          dbz_q;
    logic          ok_q;

    logic [PW-1:0] acc_d;
    logic [PW:0]   diff_d;
    logic [DW-1:0] remainder_d;
    logic          underflow_d;
    logic          dbz_d;
    logic          ok_d;

    always_comb begin
        acc_d       = divisor_q[k_q] ? (acc_q + mcand_q) : acc_q;
        // One extra bit on top so the borrow lands in diff_d[PW].
        diff_d      = {1'b0, {VW{1'b0}}, dividend_q} - {1'b0, acc_q};
        remainder_d = diff_d[DW-1:0];
        underflow_d = diff_d[PW];
        dbz_d       = (divisor_q == '0);
        ok_d        = !dbz_d && !underflow_d &&
                      (remainder_d < {{(DW-VW){1'b0}}, divisor_q});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_READY;
            dividend_q  <= '0;
            divisor_q   <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            remainder_q <= '0;
            underflow_q <= 1'b0;
            dbz_q       <= 1'b0;
            ok_q        <= 1'b0;
        end else if (start) begin
            state_q <= ST_INITS;
        end else begin
            case (state_q)
                ST_INITS: begin
                    dividend_q <= dividend;
                    divisor_q  <= divisor;
                    mcand_q    <= {{VW{1'b0}}, quotient};
                    acc_q      <= '0;
                    k_q        <= '0;
                    state_q    <= ST_MUL;
                end
                ST_MUL: begin
                    acc_q   <= acc_d;
                    mcand_q <= mcand_q << 1;
                    k_q     <= k_q + KW'(1);
                    if (k_q == KW'(VW - 1)) begin
                        state_q <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    remainder_q <= remainder_d;
                    underflow_q <= underflow_d;
                    dbz_q       <= dbz_d;
                    ok_q        <= ok_d;
                    state_q     <= ST_READY;
                end
                default: begin
                    state_q <= ST_READY;
                end
            endcase
        end
    end

    assign remainder    = remainder_q;
    assign underflow    = underflow_q;
    assign div_by_zero  = dbz_q;
    assign ok           = ok_q;
    assign result_ready = (state_q == ST_READY) & ~start;

endmodule

// File: tb/tb_remainder_check_18_18_4.sv
// Scoreboard bench for remainder_check_18_18_4: expectations pushed at start,
// popped and compared when result_ready rises.
module tb_remainder_check_18_18_4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [17:0] dividend;
    logic [3:0]  divisor;
    logic [17:0] quotient;
    logic [17:0] remainder;
    logic        underflow;
    logic        div_by_zero;
    logic        ok;
    logic        result_ready;

    typedef struct {
        logic [17:0] rem;
        logic        uf;
        logic        dbz;
        logic        ok;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    remainder_check_18_18_4 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .dividend     (dividend),
        .divisor      (divisor),
        .quotient     (quotient),
        .remainder    (remainder),
        .underflow    (underflow),
        .div_by_zero  (div_by_zero),
        .ok           (ok),
        .result_ready (result_ready)
    );

    function automatic exp_t model(input logic [17:0] a, input logic [3:0] d, input logic [17:0] q);
        exp_t   e;
        longint prod;
        longint diff;
        prod  = longint'(q) * longint'(d);
        diff  = longint'(a) - prod;
        e.rem = diff[17:0];
        e.uf  = (prod > longint'(a));
        e.dbz = (d == 4'd0);
        e.ok  = !e.dbz && !e.uf && (e.rem < {14'd0, d});
        return e;
    endfunction

    // Pulse start for one cycle; rdy_in_start is result_ready while start is high.
    task automatic issue(input logic [17:0] a, input logic [3:0] d, input logic [17:0] q,
                         input bit push, output logic rdy_in_start);
        @(negedge clk);
        dividend = a;
        divisor  = d;
        quotient = q;
        start    = 1'b1;
        if (push) sb.push_back(model(a, d, q));
        #1 rdy_in_start = result_ready;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Edge count from the start edge (E0 = 1) until result_ready; -1 on timeout.
    task automatic wait_ready(output int edges);
        edges = 1;
        while (edges < 60) begin
            @(negedge clk);
            edges++;
            if (edges == 2) begin
                dividend = 18'($urandom);
                divisor  = 4'($urandom);
                quotient = 18'($urandom);
            end
            if (result_ready) return;
        end
        edges = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor  = '0;
        quotient = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({remainder, underflow, div_by_zero, ok, result_ready} !== {18'd0, 4'b0001}) begin
            errors++;
            $display("FAIL reset_held: got rem=%0d uf=%b dbz=%b ok=%b rdy=%b, want 0 0 0 0 1",
                     remainder, underflow, div_by_zero, ok, result_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({remainder, underflow, div_by_zero, ok, result_ready} !== {18'd0, 4'b0001}) begin
            errors++;
            $display("FAIL reset_release: got rem=%0d uf=%b dbz=%b ok=%b rdy=%b, want 0 0 0 0 1",
                     remainder, underflow, div_by_zero, ok, result_ready);
        end
        last_exp = '{18'd0, 1'b0, 1'b0, 1'b0};
    endtask

    task automatic test_vectors();
        logic [17:0] ta [5] = '{18'd1000, 18'd12345, 18'd10, 18'd100, 18'd262143};
        logic [3:0]  td [5] = '{4'd7, 4'd0, 4'd3, 4'd9, 4'd15};
        logic [17:0] tq [5] = '{18'd142, 18'd0, 18'd4, 18'd10, 18'd17476};
        exp_t want [5] = '{'{18'd6, 1'b0, 1'b0, 1'b1}, '{18'd12345, 1'b0, 1'b1, 1'b0},
                           '{18'd262142, 1'b1, 1'b0, 1'b0}, '{18'd10, 1'b0, 1'b0, 1'b0},
                           '{18'd3, 1'b0, 1'b0, 1'b1}};
        logic rdy;
        int   edges;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            issue(ta[i], td[i], tq[i], 1'b1, rdy);
            checks++;
            if (rdy !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_ready_in_start: got %b want 0", i, rdy);
            end
            @(negedge clk);
            checks++;
            if ({result_ready, remainder, underflow, div_by_zero, ok} !==
                {1'b0, last_exp.rem, last_exp.uf, last_exp.dbz, last_exp.ok}) begin
                errors++;
                $display("FAIL vec%0d_busy_stale: got rdy=%b rem=%0d, want rdy=0 rem=%0d",
                         i, result_ready, remainder, last_exp.rem);
            end
            wait_ready(edges);
            edges++;
            checks++;
            if (edges !== 7) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d edges want 7", i, edges);
            end
            e = sb.pop_front();
            checks++;
            if ({remainder, underflow, div_by_zero, ok} !== {e.rem, e.uf, e.dbz, e.ok} ||
                e.rem !== want[i].rem || e.ok !== want[i].ok || e.uf !== want[i].uf) begin
                errors++;
                $display("FAIL vec%0d_result: got rem=%0d uf=%b dbz=%b ok=%b, want rem=%0d uf=%b dbz=%b ok=%b",
                         i, remainder, underflow, div_by_zero, ok, want[i].rem, want[i].uf, want[i].dbz, want[i].ok);
            end
            last_exp = e;
        end
    endtask

    task automatic test_restart();
        logic rdy;
        int   edges;
        exp_t e;
        issue(18'd262143, 4'd15, 18'd17476, 1'b0, rdy);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (result_ready !== 1'b0) begin
                errors++;
                $display("FAIL restart_busy: got rdy=%b want 0", result_ready);
            end
        end
        issue(18'd20, 4'd4, 18'd5, 1'b1, rdy);
        wait_ready(edges);
        checks++;
        if (edges !== 7) begin
            errors++;
            $display("FAIL restart_latency: got %0d edges want 7", edges);
        end
        e = sb.pop_front();
        checks++;
        if ({remainder, underflow, div_by_zero, ok} !== {18'd0, 3'b001} ||
            {e.rem, e.ok} !== {18'd0, 1'b1}) begin
            errors++;
            $display("FAIL restart_result: got rem=%0d uf=%b dbz=%b ok=%b, want rem=0 uf=0 dbz=0 ok=1",
                     remainder, underflow, div_by_zero, ok);
        end
        last_exp = e;
    endtask

    task automatic test_reset_mid();
        logic rdy;
        int   edges;
        exp_t e;
        issue(18'd99, 4'd5, 18'd30, 1'b0, rdy);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({remainder, underflow, div_by_zero, ok, result_ready} !== {18'd0, 4'b0001}) begin
            errors++;
            $display("FAIL reset_mid: got rem=%0d uf=%b dbz=%b ok=%b rdy=%b, want 0 0 0 0 1",
                     remainder, underflow, div_by_zero, ok, result_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(18'd1000, 4'd7, 18'd142, 1'b1, rdy);
        wait_ready(edges);
        checks++;
        if (edges !== 7) begin
            errors++;
            $display("FAIL after_reset_latency: got %0d edges want 7", edges);
        end
        e = sb.pop_front();
        checks++;
        if ({remainder, underflow, div_by_zero, ok} !== {e.rem, e.uf, e.dbz, e.ok}) begin
            errors++;
            $display("FAIL after_reset_result: got rem=%0d ok=%b, want rem=%0d ok=%b",
                     remainder, ok, e.rem, e.ok);
        end
        last_exp = e;
    endtask

    task automatic test_back_to_back();
        logic        rdy;
        int          edges;
        int          a;
        int          d;
        int          q;
        exp_t        e;
        for (int i = 0; i < 10; i++) begin
            a = int'($urandom_range(0, 262143));
            d = int'($urandom_range(0, 15));
            q = (d == 0) ? int'($urandom_range(0, 1000)) : (a / d) + int'($urandom_range(0, 2)) - 1;
            if (q < 0) q = 0;
            issue(18'(a), 4'(d), 18'(q), 1'b1, rdy);
            wait_ready(edges);
            checks++;
            if (edges !== 7) begin
                errors++;
                $display("FAIL b2b%0d_latency: got %0d edges want 7", i, edges);
            end
            e = sb.pop_front();
            checks++;
            if ({remainder, underflow, div_by_zero, ok} !== {e.rem, e.uf, e.dbz, e.ok}) begin
                errors++;
                $display("FAIL b2b%0d_result: a=%0d d=%0d q=%0d got rem=%0d uf=%b dbz=%b ok=%b, want rem=%0d uf=%b dbz=%b ok=%b",
                         i, a, d, q, remainder, underflow, div_by_zero, ok, e.rem, e.uf, e.dbz, e.ok);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
